l1602a_reader: RTL and testbench

- Read-side companion to the LCD 1602A write driver. Runs HD44780-style read bus cycles (RW=1) in 4-bit mode.
- Returns either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM byte (RS=1).
- Optional busy-poll mode repeats BF reads until the LCD is free, so the controller can replace fixed worst-case delays with handshaking.
- Shares the LCD pins with the write driver through a top-level mux. lcd_data_oe=0 tells the mux to release the data bus.

---
 rtl/l1602a_pkg.sv | 13 +
 rtl/l1602a_nibble_cycle.sv | 61 ++++++
 rtl/l1602a_reader.sv | 81 ++++++++
 tb/tb_l1602a_reader.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/l1602a_pkg.sv
// l1602a_pkg: shared LCD 1602A control-bit indices, FSM encodings and 20 MHz timing defaults.
package l1602a_pkg;
  localparam int RS_BIT       = 2;
  localparam int RW_BIT       = 1;
  localparam int EN_BIT       = 0;
  localparam int T_AS_DEF     = 1;
  localparam int T_PW_DEF     = 6;
  localparam int T_LO_DEF     = 6;
  localparam int POLL_MAX_DEF = 2000;
  localparam int CNT_W_DEF    = 4;
  typedef enum logic [1:0] {N_IDLE, N_SETUP, N_EN_HI, N_EN_LO} nib_state_e;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_CHECK} rd_state_e;
endpackage

// File: rtl/l1602a_nibble_cycle.sv
// l1602a_nibble_cycle: one HD44780 read strobe (setup, EN high, EN low); samples the bus on the last EN-high cycle.
module l1602a_nibble_cycle
  import l1602a_pkg::*;
#(
  parameter int T_AS  = T_AS_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_LO  = T_LO_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [3:0] data_in,
  output logic       en,
  output logic [3:0] nib,
  output logic       done
);
  localparam nib_state_e FIRST = (T_AS == 0) ? N_EN_HI : N_SETUP;
  nib_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nib_q, nib_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    nib_d   = nib_q;
    done    = 1'b0;
    case (state_q)
      N_SETUP: if (cnt_q == CNT_W'(T_AS - 1)) begin
        state_d = N_EN_HI;
        cnt_d   = '0;
      end
      N_EN_HI: if (cnt_q == CNT_W'(T_PW - 1)) begin
        state_d = N_EN_LO;
        cnt_d   = '0;
        nib_d   = data_in;
      end
      N_EN_LO: if (cnt_q == CNT_W'(T_LO - 1)) begin
        done    = 1'b1;
        state_d = go ? FIRST : N_IDLE;
        cnt_d   = '0;
      end
      default: begin
        cnt_d   = '0;
        state_d = go ? FIRST : N_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= N_IDLE;
      cnt_q   <= '0;
      nib_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
    end
  end
  assign en  = (state_q == N_EN_HI);
  assign nib = nib_q;
endmodule

// File: rtl/l1602a_reader.sv
// l1602a_reader: 4-bit HD44780 read sequencer returning BF/AC or a RAM byte, with optional busy-flag polling.
module l1602a_reader
  import l1602a_pkg::*;
#(
  parameter int T_AS     = T_AS_DEF,
  parameter int T_PW     = T_PW_DEF,
  parameter int T_LO     = T_LO_DEF,
  parameter int POLL_MAX = POLL_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_data,
  input  logic       poll_busy,
  input  logic [3:0] lcd_data_in,
  output logic [2:0] lcd_ctrl,
  output logic       lcd_data_oe,
  output logic       rdy,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy_flag,
  output logic [6:0] addr_cnt,
  output logic       timeout_err
);
  localparam int PC_W = $clog2(POLL_MAX + 1);
  rd_state_e       state_q, state_d;
  logic            nib_q, nib_d, rs_q, rs_d, poll_q, poll_d, to_q, to_d;
  logic [PC_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            accept, last, more, go, done, en, to_now;
  logic [3:0]      nib;
  l1602a_nibble_cycle #(.T_AS(T_AS), .T_PW(T_PW), .T_LO(T_LO), .CNT_W(CNT_W)) u_cycle (
    .clk(clk), .rst_n(rst_n), .go(go), .data_in(lcd_data_in), .en(en), .nib(nib), .done(done)
  );
  // The poll decision is taken on the final EN-low cycle so a repeat read adds no extra cycle.
  always_comb begin
    rdy       = (state_q != R_RUN);
    rd_valid  = (state_q == R_CHECK);
    accept    = start & rdy;
    last      = done & nib_q;
    more      = poll_q & rd_data_q[7] & (pcnt_q < PC_W'(POLL_MAX - 1));
    go        = accept | (done & ~nib_q) | (last & more);
    state_d   = (state_q == R_RUN) ? ((last & ~more) ? R_CHECK : R_RUN) : (accept ? R_RUN : R_IDLE);
    nib_d     = nib_q ^ done;
    pcnt_d    = accept ? '0 : (last & more) ? pcnt_q + 1'b1 : pcnt_q;
    rd_data_d = (done & ~nib_q) ? {nib, rd_data_q[3:0]} : done ? {rd_data_q[7:4], nib} : rd_data_q;
    rs_d      = accept ? is_data : rs_q;
    poll_d    = accept ? (poll_busy & ~is_data) : poll_q;
    to_now    = rd_valid & poll_q & rd_data_q[7];
    to_d      = accept ? 1'b0 : (to_q | to_now);
    lcd_ctrl         = '0;
    lcd_ctrl[RS_BIT] = rs_q;
    lcd_ctrl[RW_BIT] = 1'b1;
    lcd_ctrl[EN_BIT] = en;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= R_IDLE;
      nib_q     <= 1'b0;
      rs_q      <= 1'b0;
      poll_q    <= 1'b0;
      to_q      <= 1'b0;
      pcnt_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      nib_q     <= nib_d;
      rs_q      <= rs_d;
      poll_q    <= poll_d;
      to_q      <= to_d;
      pcnt_q    <= pcnt_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign lcd_data_oe = 1'b0;
  assign rd_data     = rd_data_q;
  assign busy_flag   = rd_data_q[7];
  assign addr_cnt    = rd_data_q[6:0];
  assign timeout_err = to_q | to_now;
endmodule

// File: tb/tb_l1602a_reader.sv
// tb_l1602a_reader: LCD bus model plus transaction-level reference model for the 1602A read sequencer.
module tb_l1602a_reader;
  localparam int T_AS = 1, T_PW = 6, T_LO = 6, PMAX = 4;
  localparam int RD = 2 * (T_AS + T_PW + T_LO);
  logic       clk = 0, rst_n = 0, start = 0, is_data = 0, poll_busy = 0;
  logic [3:0] lcd_data_in = 0;
  logic [2:0] lcd_ctrl;
  logic       lcd_data_oe, rdy, rd_valid, busy_flag, timeout_err;
  logic [7:0] rd_data;
  logic [6:0] addr_cnt;
  l1602a_reader #(.T_AS(T_AS), .T_PW(T_PW), .T_LO(T_LO), .POLL_MAX(PMAX), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_data(is_data), .poll_busy(poll_busy),
    .lcd_data_in(lcd_data_in), .lcd_ctrl(lcd_ctrl), .lcd_data_oe(lcd_data_oe), .rdy(rdy),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy_flag(busy_flag), .addr_cnt(addr_cnt),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask
  // LCD model: the byte list answers successive reads; the last entry repeats forever.
  logic [7:0] bytes[$];
  int  pbase = 0, pulses = 0, bad_en = 0, rw_bad = 0, oe_bad = 0, rs_bad = 0, vcount = 0, hi_len = 0;
  bit  exp_rs = 0, last_to = 0;
  function automatic logic [7:0] byte_of(input int i);
    if (bytes.size() == 0) return 8'h00;
    return (i < bytes.size()) ? bytes[i] : bytes[bytes.size() - 1];
  endfunction
  always @(negedge clk) begin
    logic [7:0] b;
    if (lcd_ctrl[1] !== 1'b1) rw_bad++;
    if (lcd_data_oe !== 1'b0) oe_bad++;
    if (!rdy && lcd_ctrl[2] !== exp_rs) rs_bad++;
    if (rd_valid) vcount++;
    if (lcd_ctrl[0]) hi_len++;
    else if (hi_len > 0) begin
      if (hi_len != T_PW) bad_en++;
      pulses++;
      hi_len = 0;
    end
    b = byte_of((pulses - pbase) / 2);
    lcd_data_in = ((pulses - pbase) % 2 == 0) ? b[7:4] : b[3:0];
  end
  task automatic do_read(input bit d, input bit p, input int nbusy, input logic [7:0] fin, input bit poke);
    int reads, cyc, e0, v0, r0;
    logic [7:0] eb;
    bit ep, eto;
    bytes.delete();
    for (int i = 0; i < nbusy; i++) bytes.push_back({1'b1, 7'($urandom)});
    bytes.push_back(fin);
    ep = p && !d;
    reads = 1;
    if (ep) begin
      eb = byte_of(0);
      while (reads < PMAX && eb[7]) begin
        eb = byte_of(reads);
        reads++;
      end
    end
    eb  = byte_of(reads - 1);
    eto = ep && eb[7];
    @(negedge clk);
    check("rdy_before", rdy, 1);
    check("to_sticky", timeout_err, last_to);
    pbase = pulses; e0 = bad_en; v0 = vcount; r0 = rs_bad + rw_bad + oe_bad;
    exp_rs = d;
    start = 1; is_data = d; poll_busy = p;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 0;
        check("rdy_busy", rdy, 0);
        check("to_clear", timeout_err, 0);
      end
      if (poke && cyc == 4) begin start = 1; is_data = ~d; poll_busy = 1; end
      if (poke && cyc == 5) start = 0;
    end while (!rd_valid && cyc < RD * PMAX + 40);
    check("latency", cyc, RD * reads + 1);
    check("rdy_with_valid", rdy, 1);
    check("rd_data", rd_data, eb);
    check("busy_flag", busy_flag, eb[7]);
    check("addr_cnt", addr_cnt, eb[6:0]);
    check("timeout", timeout_err, eto);
    check("en_pulses", pulses - pbase, 2 * reads);
    check("en_width", bad_en - e0, 0);
    check("rs_rw_oe", rs_bad + rw_bad + oe_bad - r0, 0);
    @(negedge clk);
    check("valid_1cyc", rd_valid, 0);
    check("valid_count", vcount - v0, 1);
    repeat (2) @(negedge clk);
    check("rdy_after", rdy, 1);
    last_to = eto;
  endtask
  initial begin
    int v0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", lcd_ctrl, 3'b010);
    check("rst_oe", lcd_data_oe, 0);
    check("rst_rdy", rdy, 1);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_to", timeout_err, 0);
    rst_n = 1;
    do_read(0, 0, 0, 8'h85, 0);
    do_read(1, 1, 0, 8'h4A, 0);
    do_read(0, 1, 3, 8'h12, 0);
    do_read(0, 1, 6, 8'hC3, 0);
    do_read(1, 0, 0, 8'h37, 0);
    do_read(0, 0, 0, 8'h21, 1);
    do_read(1, 0, 0, 8'h9E, 1);
    // Abort a data read during EN high.
    @(negedge clk);
    v0 = vcount; exp_rs = 1;
    start = 1; is_data = 1; poll_busy = 0;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("pre_rst_en", lcd_ctrl, 3'b111);
    #2 rst_n = 0;
    #1;
    check("midrst_ctrl", lcd_ctrl, 3'b010);
    check("midrst_rdy", rdy, 1);
    check("midrst_valid", rd_valid, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (40) @(negedge clk);
    check("abort_no_valid", vcount - v0, 0);
    last_to = 0;
    do_read(0, 0, 0, 8'h5C, 0);
    for (int t = 0; t < 12; t++)
      do_read(1'($urandom), 1'($urandom), $urandom % 6, 8'($urandom), ($urandom % 4) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
